axis_step_scheduler: RTL
========================

// Module: axis_step_scheduler
// PURPOSE
//  Shares one step/direction motor-driver channel between the theta and phi axes.
//  Takes the pos/neg move requests produced by the movement controller and grants steps
//  round-robin. Generates timed step pulses with direction setup and inter-step gap.
//  Tracks a wrapping position count per axis.
//  Sits between control_movimiento outputs and the external stepper driver pins.
// PARAMETERS
//  DIR_SETUP  2   cycles dir/axis_sel are stable before step rises (>=1)
//  PULSE_W    4   cycles step is held high (>=1)
//  STEP_GAP   16  cycles step is held low after a pulse before the next grant (>=1)
//  CNT_W      16  width of each axis position counter (two's complement, wraps)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  enable     in   1      1 = new steps may be granted
//  theta_pos  in   1      request theta step, positive direction
//  theta_neg  in   1      request theta step, negative direction
//  phi_pos    in   1      request phi step, positive direction
//  phi_neg    in   1      request phi step, negative direction
//  step       out  1      step pulse to the shared driver
//  dir        out  1      direction to the driver: 1 = pos, 0 = neg
//  axis_sel   out  1      driver channel: 0 = theta, 1 = phi
//  busy       out  1      1 while a step sequence is in progress (state != IDLE)
//  fault      out  1      1 while pos and neg are both requested on either axis
//  theta_cnt  out  CNT_W  theta position count
//  phi_cnt    out  CNT_W  phi position count
// BEHAVIOUR
//  - All outputs are registered. rst (async) forces: step=0, dir=0, axis_sel=0, busy=0,
//    fault=0, theta_cnt=0, phi_cnt=0, state=IDLE, last_axis=1 (theta wins first).
//  - Axis request valid = exactly one of pos/neg high. Both high = conflict: that axis is
//    not valid. fault <= (theta_pos&theta_neg)|(phi_pos&phi_neg) every cycle (not sticky).
//  - FSM IDLE -> SETUP -> PULSE -> GAP -> IDLE.
//  - IDLE: requests are sampled only here. If enable=1 and at least one axis is valid,
//    grant it. If both are valid, grant the axis != last_axis.
//    - On grant: latch axis_sel=granted axis, dir=pos, last_axis=granted, go to SETUP.
//  - SETUP: DIR_SETUP cycles with step=0, then PULSE.
//  - PULSE: step=1 for exactly PULSE_W cycles.
//    - On the edge leaving PULSE, the selected counter does +1 (dir=1) or -1 (dir=0),
//      modulo 2^CNT_W.
//  - GAP: step=0 for STEP_GAP cycles, then IDLE.
//  - Timing: request sampled in IDLE cycle t -> step high in cycles t+1+DIR_SETUP ..
//    t+DIR_SETUP+PULSE_W.
//    - With a continuous request the step period is 1+DIR_SETUP+PULSE_W+STEP_GAP
//      (23 at defaults).
//  - A sequence is never aborted once granted. Dropping the request, raising a conflict
//    or deasserting enable after the grant does not stop the step or its count update.
//  - dir and axis_sel hold their latched values from the grant through GAP and in IDLE
//    until the next grant.
//  - rst mid-sequence: step falls immediately (async), no count update, counters cleared.
// TESTING (defaults)
//  1. theta_pos=1 held 100 cyc after rst -> axis_sel=0, dir=1; first step high cycles 3-6
//     after the request is seen, then every 23 cyc; theta_cnt=4 after 4 pulses, phi_cnt=0.
//  2. theta_pos=1 and phi_neg=1 held -> grants alternate theta,phi,theta,phi;
//     after 4 pulses theta_cnt=2, phi_cnt=16'hFFFE.
//  3. theta_pos=theta_neg=1, phi idle -> fault=1 next cycle, no step;
//     drop theta_neg -> fault=0, theta step sequence starts next IDLE cycle.
//  4. One-cycle phi_pos in IDLE -> exactly one phi step completes, phi_cnt=1, busy low
//     23 cyc later; request removed during SETUP -> step still issued.
//  5. Counter wrap: phi_cnt=0, one phi_neg step -> phi_cnt=16'hFFFF.
//     Theta at 16'hFFFF plus one theta_pos step -> 0.
//  6. rst pulsed during PULSE -> step=0 same cycle, busy=0, counts=0;
//     enable=0 with requests held -> no steps, busy stays 0.

Source files
------------

// File: rtl/axis_step_scheduler.sv
// Round-robin scheduler sharing one step/dir driver channel between the theta and phi axes.
// Emits timed step pulses and keeps a wrapping position count per axis.
module axis_step_scheduler #(
  parameter int DIR_SETUP = 2,
  parameter int PULSE_W   = 4,
  parameter int STEP_GAP  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             theta_pos,
  input  logic             theta_neg,
  input  logic             phi_pos,
  input  logic             phi_neg,
  output logic             step,
  output logic             dir,
  output logic             axis_sel,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] theta_cnt,
  output logic [CNT_W-1:0] phi_cnt
);

  localparam int TMAX_A = (DIR_SETUP > PULSE_W) ? DIR_SETUP : PULSE_W;
  localparam int TMAX   = (TMAX_A > STEP_GAP) ? TMAX_A : STEP_GAP;
  localparam int TW     = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [TW-1:0]    timer_r;
  logic [TW-1:0]    timer_s;
  logic             last_axis_r;
  logic             grant_s;
  logic             grant_axis_s;
  logic             grant_dir_s;
  logic             cnt_upd_s;
  logic             theta_v_s;
  logic             phi_v_s;
  logic [CNT_W-1:0] delta_s;

  logic             step_r;
  logic             dir_r;
  logic             axis_sel_r;
  logic             busy_r;
  logic             fault_r;
  logic [CNT_W-1:0] theta_cnt_r;
  logic [CNT_W-1:0] phi_cnt_r;

  // A conflicting pos+neg pair never counts as a request.
  assign theta_v_s = theta_pos ^ theta_neg;
  assign phi_v_s   = phi_pos ^ phi_neg;
  assign delta_s   = dir_r ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b1}};

  // Next-state, arbitration and phase timing.
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    grant_s      = 1'b0;
    grant_axis_s = last_axis_r;
    grant_dir_s  = 1'b0;
    cnt_upd_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && (theta_v_s || phi_v_s)) begin
          grant_s = 1'b1;
          if (theta_v_s && phi_v_s) begin
            grant_axis_s = ~last_axis_r;
          end else if (phi_v_s) begin
            grant_axis_s = 1'b1;
          end else begin
            grant_axis_s = 1'b0;
          end
          grant_dir_s = grant_axis_s ? phi_pos : theta_pos;
          state_s     = SETUP;
          timer_s     = '0;
        end else begin
          state_s = IDLE;
          timer_s = '0;
        end
      end
      SETUP: begin
        if (timer_r == TW'(DIR_SETUP - 1)) begin
          state_s = PULSE;
          timer_s = '0;
        end else begin
          timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      PULSE: begin
        if (timer_r == TW'(PULSE_W - 1)) begin
          state_s   = GAP;
          timer_s   = '0;
          cnt_upd_s = 1'b1;
        end else begin
          timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      GAP: begin
        if (timer_r == TW'(STEP_GAP - 1)) begin
          state_s = IDLE;
          timer_s = '0;
        end else begin
          timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = '0;
      end
    endcase
  end

  // State, latched grant, registered outputs and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      timer_r     <= '0;
      last_axis_r <= 1'b1;
      step_r      <= 1'b0;
      dir_r       <= 1'b0;
      axis_sel_r  <= 1'b0;
      busy_r      <= 1'b0;
      fault_r     <= 1'b0;
      theta_cnt_r <= '0;
      phi_cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      step_r  <= (state_s == PULSE);
      busy_r  <= (state_s != IDLE);
      fault_r <= (theta_pos & theta_neg) | (phi_pos & phi_neg);
      if (grant_s) begin
        axis_sel_r  <= grant_axis_s;
        dir_r       <= grant_dir_s;
        last_axis_r <= grant_axis_s;
      end
      if (cnt_upd_s && !axis_sel_r) begin
        theta_cnt_r <= theta_cnt_r + delta_s;
      end
      if (cnt_upd_s && axis_sel_r) begin
        phi_cnt_r <= phi_cnt_r + delta_s;
      end
    end
  end

  assign step      = step_r;
  assign dir       = dir_r;
  assign axis_sel  = axis_sel_r;
  assign busy      = busy_r;
  assign fault     = fault_r;
  assign theta_cnt = theta_cnt_r;
  assign phi_cnt   = phi_cnt_r;

endmodule
